sm_als_sensor_model: RTL and testbench
======================================

Name: sm_als_sensor_model

Overview:
- Synthesizable clocked model of the PmodALS ambient light sensor (ADC081S021-style, 8-bit, SPI mode 3 read-only slave).
- Sits on the board/bench side of the CPU's ALS SPI master and answers every CS-framed transfer with a known 8-bit light value.
- Master lines are oversampled on the model clock.
- The value advances after each complete frame, so firmware reads are deterministic and checkable.

Parameters:
- INIT_VALUE, 8'hA5: light value returned after reset.
- STEP, 8'h01: added (mod 256) to the value after each complete frame; 0 gives a constant value.
- FRAME_BITS, 16: SCK falling edges in a complete frame.

Ports:
- clk  in  1  model clock; must be at least 8x the SCK frequency.
- rst_n  in  1  synchronous active-low reset.
- cs  in  1  chip select from master, active low; asynchronous to clk.
- sck  in  1  SPI clock from master, idles high; asynchronous to clk.
- sdo  out  1  serial data to master.
- value_load  in  1  one-cycle strobe; loads value_in as the next value.
- value_in  in  8  value loaded by value_load.
- value  out  8  value served by the current/next frame.
- frame_done  out  1  one-cycle pulse on completion of a full frame.
- err  out  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Synchronizers: cs and sck each pass through a 2-flop synchronizer plus one history flop for edge detection.
  - Synchronizer flops reset to 1, so no frame can start until cs is seen high.
- Reset state: sdo=0, value=INIT_VALUE, bit index=0, frame_done=0, err=0, FSM=IDLE.
- Frame format (bit index 0..15):
  - idx 0-2: 0.
  - idx 3-10: value[7:0], MSB first.
  - idx 11-15: 0.
  - Master samples on SCK rising edges, so a full read yields the 16-bit word {3'b0, value, 5'b0}.
- FSM states:
  - IDLE: sdo=0. A synced cs falling edge → ACTIVE, idx=0, value latched into the shift source, sdo=bit[0].
  - ACTIVE: each synced sck falling edge → idx+1, sdo=bit[idx+1].
    - At idx=FRAME_BITS-1, further falling edges saturate; sdo=0.
    - A synced cs rising edge → IDLE.
- Latency: sdo updates on the 3rd rising clk edge after the cs/sck transition is first sampled. SCK half-period must be at least 4 clk cycles.
- Frame completion:
  - On cs rising, if at least FRAME_BITS falling edges were counted: value <= value+STEP (8-bit wrap, 8'hFF+1=8'h00) and frame_done pulses one cycle.
  - Otherwise the frame is aborted: value is unchanged and there is no pulse.
- The value latched at frame start is served for the whole frame, even if value changes during it.
- value_load:
  - In IDLE, value <= value_in the next cycle.
  - In ACTIVE, the load is held pending and applied at cs rise, taking priority over the STEP increment.
- Simultaneous cs rise and sck fall in the same cycle: cs wins and the edge is not counted.
- Reset mid-frame: immediate return to the reset state. A frame starts only after cs is seen high, then falls.

Optional Feature:
- Macro: SM_ALS_MODEL_PROTOCOL_CHECK_EN.
- When defined, err sets (sticky until reset) on any of:
  - cs rising with fewer than FRAME_BITS counted edges;
  - more than FRAME_BITS sck falling edges in a frame;
  - sck synced low at a cs falling edge (mode 3 violation).
- When not defined, err is tied to 0 and no check logic is built.

Test Plan:
- Reset, then one 16-SCK frame (SCK period 16 clk) → master word 0x14A0 (value A5); frame_done pulses once; value becomes 8'hA6.
- Second frame → word 0x14C0; value becomes 8'hA7.
- value_load with value_in=8'hFF in IDLE, frame → word 0x1FE0; value wraps to 8'h00.
- Abort: cs raised after 8 SCK edges → no frame_done, value unchanged; next full frame returns the same value. With the macro, err=1.
- value_load=8'h3C asserted mid-frame → the current frame still returns the old value; value=8'h3C afterwards (not 8'h3D).
- Reset asserted mid-frame → sdo=0, value=8'hA5; the next full frame returns 0x14A0.

Source files
------------

// File: rtl/sm_als_sensor_model.sv
// Clocked model of a PmodALS (ADC081S021-style) SPI mode 3 read-only slave.
// Optional protocol checking is built when SM_ALS_MODEL_PROTOCOL_CHECK_EN is defined.
module sm_als_sensor_model #(
    parameter logic [7:0] INIT_VALUE = 8'hA5,
    parameter logic [7:0] STEP       = 8'h01,
    parameter int         FRAME_BITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       sck,
    output logic       sdo,
    input  logic       value_load,
    input  logic [7:0] value_in,
    output logic [7:0] value,
    output logic       frame_done,
    output logic       err
);
    localparam int             CW        = $clog2(FRAME_BITS + 1);
    localparam logic [0:0]     ST_IDLE   = 1'b0;
    localparam logic [0:0]     ST_ACTIVE = 1'b1;
    localparam logic [CW-1:0]  FULL_CNT  = CW'(FRAME_BITS);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    logic          cs_s1_r, cs_s2_r, cs_h_r;
    logic          sck_s1_r, sck_s2_r, sck_h_r;
    logic [1:0]    warm_r;
    logic          armed_r;
    logic [0:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [7:0]    shift_r;
    logic          sdo_r;
    logic [7:0]    value_r;
    logic          frame_done_r;
    logic          pend_r;
    logic [7:0]    pend_val_r;

    logic          cs_fall_s, cs_rise_s, sck_fall_s, full_s;
    logic [CW:0]   nxt_idx_s;

    // Word layout: three leading zeros, value MSB first, then zeros.
    function automatic logic frame_bit(input logic [7:0] src, input logic [CW:0] n);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (n == (CW+1)'(3 + i)) begin
                b = src[7-i];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    // A cs fall only counts once cs has been genuinely sampled high after reset.
    assign cs_fall_s  = cs_h_r & ~cs_s2_r & armed_r;
    assign cs_rise_s  = ~cs_h_r & cs_s2_r;
    assign sck_fall_s = sck_h_r & ~sck_s2_r;
    assign full_s     = (cnt_r == FULL_CNT);
    assign nxt_idx_s  = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};

    // Input synchronizers, edge history and post-reset arming.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_s1_r  <= 1'b1;
            cs_s2_r  <= 1'b1;
            cs_h_r   <= 1'b1;
            sck_s1_r <= 1'b1;
            sck_s2_r <= 1'b1;
            sck_h_r  <= 1'b1;
            warm_r   <= 2'd0;
            armed_r  <= 1'b0;
        end else begin
            cs_s1_r  <= cs;
            cs_s2_r  <= cs_s1_r;
            cs_h_r   <= cs_s2_r;
            sck_s1_r <= sck;
            sck_s2_r <= sck_s1_r;
            sck_h_r  <= sck_s2_r;
            if (warm_r != 2'd3) begin
                warm_r <= warm_r + 2'd1;
            end else begin
                warm_r <= warm_r;
            end
            armed_r <= armed_r | (warm_r[1] & cs_s2_r);
        end
    end

    // Frame FSM, shift output, value bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            shift_r      <= 8'h00;
            sdo_r        <= 1'b0;
            value_r      <= INIT_VALUE;
            frame_done_r <= 1'b0;
            pend_r       <= 1'b0;
            pend_val_r   <= 8'h00;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_r <= ST_ACTIVE;
                        cnt_r   <= '0;
                        shift_r <= value_r;
                        sdo_r   <= frame_bit(value_r, '0);
                    end else begin
                        sdo_r <= 1'b0;
                    end
                    if (value_load) begin
                        value_r <= value_in;
                    end else begin
                        value_r <= value_r;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise_s) begin
                        // A pending load wins over the per-frame step.
                        state_r      <= ST_IDLE;
                        sdo_r        <= 1'b0;
                        pend_r       <= 1'b0;
                        frame_done_r <= full_s;
                        if (value_load) begin
                            value_r <= value_in;
                        end else if (pend_r) begin
                            value_r <= pend_val_r;
                        end else if (full_s) begin
                            value_r <= value_r + STEP;
                        end else begin
                            value_r <= value_r;
                        end
                    end else begin
                        if (value_load) begin
                            pend_r     <= 1'b1;
                            pend_val_r <= value_in;
                        end else begin
                            pend_r <= pend_r;
                        end
                        if (sck_fall_s) begin
                            if (!full_s) begin
                                cnt_r <= cnt_r + CNT_ONE;
                            end else begin
                                cnt_r <= cnt_r;
                            end
                            sdo_r <= frame_bit(shift_r, nxt_idx_s);
                        end else begin
                            sdo_r <= sdo_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sdo_r   <= 1'b0;
                end
            endcase
        end
    end

    assign sdo        = sdo_r;
    assign value      = value_r;
    assign frame_done = frame_done_r;

`ifdef SM_ALS_MODEL_PROTOCOL_CHECK_EN
    logic err_r;

    // Sticky protocol error: short frame, overrun, or sck low at frame start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE && cs_fall_s && !sck_s2_r) ||
                     (state_r == ST_ACTIVE && cs_rise_s && !full_s) ||
                     (state_r == ST_ACTIVE && !cs_rise_s && sck_fall_s && full_s)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sm_als_sensor_model.sv
// Self-checking bench for sm_als_sensor_model: directed table, reset corner case, random frames.
module tb_sm_als_sensor_model;
    localparam int OP_FULL = 0, OP_LOAD = 1, OP_MIDLOAD = 2, OP_ABORT = 3;
`ifdef SM_ALS_MODEL_PROTOCOL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b1;
    logic       sck = 1'b1;
    logic       value_load = 1'b0;
    logic [7:0] value_in = 8'h00;
    logic       sdo, frame_done, err;
    logic [7:0] value;

    int tests = 0;
    int fails = 0;
    int fd_total = 0;
    logic [7:0] m_value;
    logic       m_err;

    typedef struct {
        int         op;
        logic [7:0] data;
        int         nf;
        logic [15:0] exp_word;
        logic [7:0] exp_value;
        int         exp_done;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    sm_als_sensor_model dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .sck(sck), .sdo(sdo),
        .value_load(value_load), .value_in(value_in), .value(value),
        .frame_done(frame_done), .err(err)
    );

    always @(negedge clk) begin
        if (frame_done) fd_total++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Mode 3 master: each bit sampled at the end of the SCK high phase, before its falling edge.
    task automatic frame(input int nf, input int half, input bit ld, input logic [7:0] d,
                         output logic [15:0] word);
        word = 16'h0000;
        @(negedge clk);
        cs = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nf; i++) begin
            if (i < 16) word = {word[14:0], sdo};
            sck = 1'b0;
            if (ld && i == 5) begin
                value_load = 1'b1;
                value_in = d;
                @(negedge clk);
                value_load = 1'b0;
                repeat (half - 1) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            sck = 1'b1;
            repeat (half) @(negedge clk);
        end
        cs = 1'b1;
        repeat (half + 3) @(negedge clk);
    endtask

    task automatic run_op(input int op, input logic [7:0] d, input int nf, input int half,
                          output logic [15:0] word, output int done);
        int fd0;
        fd0 = fd_total;
        word = 16'h0000;
        if (op == OP_LOAD) begin
            @(negedge clk);
            value_load = 1'b1;
            value_in = d;
            @(negedge clk);
            value_load = 1'b0;
            @(negedge clk);
        end else begin
            frame(nf, half, op == OP_MIDLOAD, d, word);
        end
        done = fd_total - fd0;
    endtask

    initial begin
        logic [15:0] word;
        int done;
        int op, nf, half;
        logic [7:0] d;
        logic [15:0] exp_word;

        vecs[0] = '{OP_FULL,    8'h00, 16, 16'h14A0, 8'hA6, 1};
        vecs[1] = '{OP_FULL,    8'h00, 16, 16'h14C0, 8'hA7, 1};
        vecs[2] = '{OP_LOAD,    8'hFF,  0, 16'h0000, 8'hFF, 0};
        vecs[3] = '{OP_FULL,    8'h00, 16, 16'h1FE0, 8'h00, 1};
        vecs[4] = '{OP_LOAD,    8'h5A,  0, 16'h0000, 8'h5A, 0};
        vecs[5] = '{OP_ABORT,   8'h00,  8, 16'h0000, 8'h5A, 0};
        vecs[6] = '{OP_FULL,    8'h00, 16, 16'h0B40, 8'h5B, 1};
        vecs[7] = '{OP_MIDLOAD, 8'h3C, 16, 16'h0B60, 8'h3C, 1};

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_sdo", {31'd0, sdo}, 32'd0);
        check("reset_value", {24'd0, value}, 32'h0000_00A5);
        check("reset_done", {31'd0, frame_done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        m_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            run_op(vecs[k].op, vecs[k].data, vecs[k].nf, 8, word, done);
            if (vecs[k].op == OP_ABORT) m_err = 1'b1;
            if (vecs[k].op == OP_FULL || vecs[k].op == OP_MIDLOAD)
                check($sformatf("vec%0d_word", k), {16'd0, word}, {16'd0, vecs[k].exp_word});
            check($sformatf("vec%0d_value", k), {24'd0, value}, {24'd0, vecs[k].exp_value});
            check($sformatf("vec%0d_done", k), done, vecs[k].exp_done);
            check($sformatf("vec%0d_err", k), {31'd0, err}, {31'd0, CHK & m_err});
            check($sformatf("vec%0d_idle_sdo", k), {31'd0, sdo}, 32'd0);
        end

        // Reset in the middle of a frame serving 8'h3C (idx 6 carries a 1)
        done = fd_total;
        @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            sck = 1'b0;
            repeat (8) @(negedge clk);
            sck = 1'b1;
            repeat (8) @(negedge clk);
        end
        check("midrst_pre_sdo", {31'd0, sdo}, 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_sdo", {31'd0, sdo}, 32'd0);
        check("midrst_value", {24'd0, value}, 32'h0000_00A5);
        check("midrst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        m_err = 1'b0;
        repeat (4) @(negedge clk);
        // cs still low: clocking must not start a frame until cs has been seen high
        for (int i = 0; i < 4; i++) begin
            sck = 1'b0;
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
        end
        check("norearm_sdo", {31'd0, sdo}, 32'd0);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check("norearm_done", fd_total - done, 0);
        run_op(OP_FULL, 8'h00, 16, 8, word, done);
        check("postrst_word", {16'd0, word}, 32'h0000_14A0);
        check("postrst_value", {24'd0, value}, 32'h0000_00A6);
        check("postrst_done", done, 1);

        // Random frames against the reference model
        m_value = 8'hA6;
        for (int k = 0; k < 24; k++) begin
            op   = $urandom_range(0, 4);
            half = $urandom_range(4, 7);
            d    = 8'($urandom_range(0, 255));
            nf   = 16;
            exp_word = {3'b000, m_value, 5'b00000};
            case (op)
                0: begin run_op(OP_FULL, d, 16, half, word, done); m_value = m_value + 8'h01; end
                1: begin run_op(OP_LOAD, d, 0, half, word, done); m_value = d; end
                2: begin run_op(OP_MIDLOAD, d, 16, half, word, done); m_value = d; end
                3: begin nf = $urandom_range(1, 15); run_op(OP_ABORT, d, nf, half, word, done); m_err = 1'b1; end
                default: begin nf = 17; run_op(OP_FULL, d, 17, half, word, done); m_value = m_value + 8'h01; m_err = 1'b1; end
            endcase
            if (op == 0 || op == 2 || op == 4)
                check($sformatf("rnd%0d_word", k), {16'd0, word}, {16'd0, exp_word});
            check($sformatf("rnd%0d_value", k), {24'd0, value}, {24'd0, m_value});
            check($sformatf("rnd%0d_done", k), done, (op == 0 || op == 2 || op == 4) ? 1 : 0);
            check($sformatf("rnd%0d_err", k), {31'd0, err}, {31'd0, CHK & m_err});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
